// File: rtl/raw_stream_tx.sv
// raw_stream_tx
// Raster pixel transmitter feeding a 5x5 window stage. A frame is requested
// with a one-cycle start pulse while idle; the frame dimensions and Bayer
// phase are checked and latched, then h_active x v_active upstream pixels are
// accepted through a valid/ready handshake and re-emitted one cycle later on
// dout/clken. Idle (blanking) cycles are inserted after every line
// (H_BLANK) and after the last line of the frame (V_BLANK).
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   start, abort        frame request (idle only) and synchronous abort
//   h_active_cfg        pixels per line (11 bits)
//   v_active_cfg        lines per frame (11 bits)
//   bayer_cfg           one-hot Bayer phase of pixel (0,0)
//   src_data/src_valid  upstream pixel stream
//   src_ready           pixel accepted this cycle when src_valid is high
//   dout, clken         registered pixel and its valid qualifier
//   h_active_out,
//   v_active_out,
//   bayer_state_start   configuration latched for the current frame
//   frame_start         pulse with the first clken of a frame
//   frame_done          pulse when the frame's vertical blanking ends
//   cfg_err             pulse when a start request is rejected
module raw_stream_tx #(
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 64,
  parameter int MAX_DIM = 2047
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] h_active_cfg,
  input  logic [10:0] v_active_cfg,
  input  logic [3:0]  bayer_cfg,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [7:0]  dout,
  output logic        clken,
  output logic [10:0] h_active_out,
  output logic [10:0] v_active_out,
  output logic [3:0]  bayer_state_start,
  output logic        frame_start,
  output logic        frame_done,
  output logic        cfg_err
);

  localparam logic [11:0] MAX_DIM_W = 12'(MAX_DIM);
  localparam logic [15:0] H_BLANK_W = 16'(H_BLANK);
  localparam logic [15:0] V_BLANK_W = 16'(V_BLANK);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [15:0] blank_cnt;

  logic cfg_legal;
  logic beat;
  logic line_end;
  logic last_line;
  logic start_ok;
  logic start_bad;
  logic done_set;
  logic leave_frame;

  // A start is only legal with both dimensions in 1..MAX_DIM and exactly one
  // Bayer phase bit set.
  always_comb begin
    cfg_legal = (h_active_cfg != 11'd0) && ({1'b0, h_active_cfg} <= MAX_DIM_W) &&
                (v_active_cfg != 11'd0) && ({1'b0, v_active_cfg} <= MAX_DIM_W) &&
                $onehot(bayer_cfg);
  end

  // Abort masks ready so a beat coinciding with it is never accepted.
  assign src_ready = (state == ACTIVE) && !abort;
  assign beat      = src_valid && src_ready;
  assign line_end  = (h_cnt == h_active_out - 11'd1);
  assign last_line = (v_cnt == v_active_out - 11'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Blanking states exit when the down-counter is about to
  // reach zero, so each blanking state lasts exactly its parameter in cycles.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_legal) begin
            state_next = ACTIVE;
            start_ok   = 1'b1;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (beat && line_end) begin
          if (last_line) begin
            if (V_BLANK == 0) begin
              state_next = IDLE;
              done_set   = 1'b1;
            end else begin
              state_next = VBLANK;
            end
          end else if (H_BLANK != 0) begin
            state_next = HBLANK;
          end
        end
      end
      HBLANK: begin
        if (abort)                   state_next = IDLE;
        else if (blank_cnt <= 16'd1) state_next = ACTIVE;
      end
      VBLANK: begin
        if (abort) begin
          state_next = IDLE;
        end else if (blank_cnt <= 16'd1) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign leave_frame = (state != IDLE) && (state_next == IDLE);

  // Datapath: pixel register, pulses, latched configuration and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout              <= 8'd0;
      clken             <= 1'b0;
      frame_start       <= 1'b0;
      frame_done        <= 1'b0;
      cfg_err           <= 1'b0;
      h_active_out      <= 11'd0;
      v_active_out      <= 11'd0;
      bayer_state_start <= 4'd0;
      h_cnt             <= 11'd0;
      v_cnt             <= 11'd0;
      blank_cnt         <= 16'd0;
    end else begin
      clken       <= beat;
      frame_start <= beat && (h_cnt == 11'd0) && (v_cnt == 11'd0);
      frame_done  <= done_set;
      cfg_err     <= start_bad;
      if (beat) dout <= src_data;

      if (start_ok) begin
        h_active_out      <= h_active_cfg;
        v_active_out      <= v_active_cfg;
        bayer_state_start <= bayer_cfg;
        h_cnt             <= 11'd0;
        v_cnt             <= 11'd0;
        blank_cnt         <= 16'd0;
      end else if (leave_frame) begin
        h_cnt     <= 11'd0;
        v_cnt     <= 11'd0;
        blank_cnt <= 16'd0;
      end else if (beat) begin
        if (line_end) begin
          h_cnt     <= 11'd0;
          v_cnt     <= v_cnt + 11'd1;
          blank_cnt <= last_line ? V_BLANK_W : H_BLANK_W;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end else if ((state == HBLANK || state == VBLANK) && blank_cnt != 16'd0) begin
        blank_cnt <= blank_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_raw_stream_tx.sv
// Testbench for raw_stream_tx: configuration vector table, exact-timing frame
// runs, abort, random-gap streaming against a pixel queue, large-frame
// configuration hold and mid-line reset.
module tb_raw_stream_tx;

  localparam int HB = 2;
  localparam int VB = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [10:0] h_active_cfg;
  logic [10:0] v_active_cfg;
  logic [3:0]  bayer_cfg;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_ready;
  logic [7:0]  dout;
  logic        clken;
  logic [10:0] h_active_out;
  logic [10:0] v_active_out;
  logic [3:0]  bayer_state_start;
  logic        frame_start;
  logic        frame_done;
  logic        cfg_err;

  int checks = 0;
  int passes = 0;

  raw_stream_tx #(.H_BLANK(HB), .V_BLANK(VB), .MAX_DIM(2047)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .h_active_cfg(h_active_cfg), .v_active_cfg(v_active_cfg), .bayer_cfg(bayer_cfg),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .dout(dout), .clken(clken), .h_active_out(h_active_out), .v_active_out(v_active_out),
    .bayer_state_start(bayer_state_start), .frame_start(frame_start),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic [3:0]  b;
    logic        exp_err;
  } cfg_vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic vld, input logic [7:0] d);
    start     = st;
    abort     = ab;
    src_valid = vld;
    src_data  = d;
  endtask

  // Cycle k (0 = start cycle) carries an accepted pixel when it falls inside
  // one of the v line windows; lines are h+HB cycles apart.
  function automatic bit in_line(input int k, input int h, input int v);
    for (int l = 0; l < v; l++) begin
      if (k >= 1 + l * (h + HB) && k < 1 + l * (h + HB) + h) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] pix_of(input int k);
    return 8'(k * 37 + 5);
  endfunction

  // Full frame with src_valid held high; every cycle's handshake, clken,
  // data, frame_start and frame_done are compared to the arithmetic timeline.
  task automatic run_full_frame(input int h, input int v, input string tag);
    int last_beat;
    int done_cycle;
    int pulses;
    last_beat  = (v - 1) * (h + HB) + h;
    done_cycle = last_beat + VB + 1;
    pulses     = 0;
    h_active_cfg = 11'(h);
    v_active_cfg = 11'(v);
    bayer_cfg    = 4'b0001;
    for (int k = 0; k <= done_cycle + 2; k++) begin
      applyStimulus(k == 0, 1'b0, 1'b1, pix_of(k));
      @(negedge clk);
      if (k >= 1) begin
        checkOutput({tag, "_ready"}, 32'(src_ready), 32'(in_line(k, h, v)));
        checkOutput({tag, "_clken"}, 32'(clken), 32'(in_line(k - 1, h, v)));
        checkOutput({tag, "_done"}, 32'(frame_done), 32'(k == done_cycle));
        checkOutput({tag, "_fstart"}, 32'(frame_start), 32'(k == 2));
        if (clken) begin
          pulses++;
          checkOutput({tag, "_dout"}, 32'(dout), 32'(pix_of(k - 1)));
        end
      end
      tick;
    end
    checkOutput({tag, "_pulses"}, 32'(pulses), 32'(h * v));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  cfg_vec_t    vecs[8];
  logic [7:0]  pix[24];
  logic [10:0] lat_h;
  logic [10:0] lat_v;
  logic [3:0]  lat_b;

  initial begin
    int idx;
    int out_idx;
    bit done_seen;
    bit accepted;

    vecs[0] = '{11'd0,    11'd3,    4'b0001, 1'b1};
    vecs[1] = '{11'd4,    11'd3,    4'b0011, 1'b1};
    vecs[2] = '{11'd4,    11'd0,    4'b0001, 1'b1};
    vecs[3] = '{11'd4,    11'd3,    4'b0000, 1'b1};
    vecs[4] = '{11'd4,    11'd3,    4'b1000, 1'b0};
    vecs[5] = '{11'd0,    11'd0,    4'b0100, 1'b1};
    vecs[6] = '{11'd1,    11'd1,    4'b0010, 1'b0};
    vecs[7] = '{11'd2047, 11'd2047, 4'b0001, 1'b0};

    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    h_active_cfg = 11'd0;
    v_active_cfg = 11'd0;
    bayer_cfg    = 4'd0;
    rst_n = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_ready", 32'(src_ready), 32'd0);
    checkOutput("rst_clken", 32'(clken), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_hout", 32'(h_active_out), 32'd0);
    checkOutput("rst_bayer", 32'(bayer_state_start), 32'd0);
    tick;

    // Configuration table.
    lat_h = 11'd0; lat_v = 11'd0; lat_b = 4'd0;
    for (int i = 0; i < 8; i++) begin
      h_active_cfg = vecs[i].h;
      v_active_cfg = vecs[i].v;
      bayer_cfg    = vecs[i].b;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
      tick;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      if (!vecs[i].exp_err) begin
        lat_h = vecs[i].h; lat_v = vecs[i].v; lat_b = vecs[i].b;
      end
      checkOutput("cfg_err", 32'(cfg_err), 32'(vecs[i].exp_err));
      checkOutput("cfg_ready", 32'(src_ready), 32'(!vecs[i].exp_err));
      checkOutput("cfg_hout", 32'(h_active_out), 32'(lat_h));
      checkOutput("cfg_vout", 32'(v_active_out), 32'(lat_v));
      checkOutput("cfg_bayer", 32'(bayer_state_start), 32'(lat_b));
      abort = 1'b1;
      tick;
      abort = 1'b0;
      @(negedge clk);
      checkOutput("cfg_err_pulse", 32'(cfg_err), 32'd0);
      checkOutput("cfg_idle", 32'(src_ready), 32'd0);
      tick;
    end

    // Exact-timing 4x3 frame.
    run_full_frame(4, 3, "frame");

    // Abort on the 5th beat (cycle 7), then a full frame.
    h_active_cfg = 11'd4; v_active_cfg = 11'd3; bayer_cfg = 4'b0001;
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(k == 0, k == 7, 1'b1, pix_of(k));
      @(negedge clk);
      if (k >= 1) begin
        checkOutput("abort_ready", 32'(src_ready), 32'(in_line(k, 4, 3) && k < 7));
        checkOutput("abort_clken", 32'(clken), 32'(in_line(k - 1, 4, 3) && k - 1 < 7));
        checkOutput("abort_done", 32'(frame_done), 32'd0);
      end
      tick;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    tick;
    run_full_frame(4, 3, "post_abort");

    // Random src_valid gaps on a 6x4 frame against a pixel queue.
    for (int i = 0; i < 24; i++) pix[i] = 8'($urandom);
    h_active_cfg = 11'd6; v_active_cfg = 11'd4; bayer_cfg = 4'b0010;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    tick;
    idx = 0; out_idx = 0; done_seen = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      applyStimulus(1'b0, 1'b0, ($urandom_range(0, 3) != 0) && idx < 24,
                    (idx < 24) ? pix[idx] : 8'd0);
      @(negedge clk);
      if (clken) begin
        if (out_idx < 24) checkOutput("rand_dout", 32'(dout), 32'(pix[out_idx]));
        out_idx++;
      end
      if (frame_done) done_seen = 1'b1;
      accepted = src_valid && src_ready;
      tick;
      if (accepted) idx++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("rand_done_seen", 32'(done_seen), 32'd1);
    checkOutput("rand_clken_count", 32'(out_idx), 32'd24);
    checkOutput("rand_accepted", 32'(idx), 32'd24);
    tick;

    // 1920x1080 with Bayer 0100: configuration held, first line wrap timing.
    h_active_cfg = 11'd1920; v_active_cfg = 11'd1080; bayer_cfg = 4'b0100;
    for (int k = 0; k <= 1925; k++) begin
      applyStimulus(k == 0, 1'b0, 1'b1, pix_of(k));
      if (k == 1) begin
        h_active_cfg = 11'd5; v_active_cfg = 11'd7; bayer_cfg = 4'b0001;
      end
      @(negedge clk);
      if (k == 1 || k == 2 || k == 960 || k == 1920 || k == 1921 || k == 1923) begin
        checkOutput("big_hout", 32'(h_active_out), 32'd1920);
        checkOutput("big_vout", 32'(v_active_out), 32'd1080);
        checkOutput("big_bayer", 32'(bayer_state_start), 32'b0100);
        checkOutput("big_ready", 32'(src_ready), 32'(in_line(k, 1920, 1080)));
      end
      tick;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    tick;

    // Reset asserted mid-line.
    h_active_cfg = 11'd4; v_active_cfg = 11'd3; bayer_cfg = 4'b1000;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h5a);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'ha5);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(src_ready), 32'd0);
    checkOutput("mid_rst_clken", 32'(clken), 32'd0);
    checkOutput("mid_rst_dout", 32'(dout), 32'd0);
    checkOutput("mid_rst_hout", 32'(h_active_out), 32'd0);
    checkOutput("mid_rst_vout", 32'(v_active_out), 32'd0);
    checkOutput("mid_rst_bayer", 32'(bayer_state_start), 32'd0);
    checkOutput("mid_rst_pulses", 32'({frame_start, frame_done, cfg_err}), 32'd0);
    repeat (2) tick;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      @(negedge clk);
      checkOutput("post_rst_ready", 32'(src_ready), 32'd0);
      checkOutput("post_rst_clken", 32'(clken), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    tick;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/raw_stream_tx.md
RAW_STREAM_TX -- requirements
Module: raw_stream_tx

Interface
REQ-001 The block SHALL have parameter H_BLANK, default 16, meaning idle cycles inserted after each non-last line.
REQ-002 The block SHALL have parameter V_BLANK, default 64, meaning idle cycles inserted after the last line of a frame.
REQ-003 The block SHALL have parameter MAX_DIM, default 2047, meaning the largest legal h_active_in/v_active_in.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle frame request, honoured only in IDLE.
REQ-007 abort  input  1  synchronous abort of the current frame.
REQ-008 h_active_cfg  input  11  pixels per line.
REQ-009 v_active_cfg  input  11  lines per frame.
REQ-010 bayer_cfg  input  4  one-hot Bayer phase of pixel (0,0): 0001, 0010, 0100 or 1000.
REQ-011 src_data  input  8  upstream raw pixel.
REQ-012 src_valid  input  1  upstream pixel valid.
REQ-013 src_ready  output  1  block accepts src_data this cycle.
REQ-014 dout  output  8  raster pixel to the 5x5 window stage (its din).
REQ-015 clken  output  1  dout valid qualifier (window stage clken).
REQ-016 h_active_out / v_active_out  output  11 each  latched frame dimensions, stable for the whole frame.
REQ-017 bayer_state_start  output  4  latched bayer_cfg, stable for the whole frame.
REQ-018 frame_start  output  1  one-cycle pulse coincident with the first clken of a frame.
REQ-019 frame_done  output  1  one-cycle pulse at the end of V_BLANK.
REQ-020 cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-021 The state machine SHALL have states IDLE, ACTIVE, HBLANK, VBLANK.
REQ-022 IDLE+start with legal config (both dims 1..MAX_DIM, bayer_cfg one-hot) -> latch dims and bayer_cfg, clear h_cnt/v_cnt, go ACTIVE next cycle.
REQ-023 IDLE+start with illegal config -> stay IDLE and pulse cfg_err the next cycle; latched outputs unchanged.
REQ-024 src_ready SHALL be 1 only in ACTIVE; a beat is src_valid&&src_ready.
REQ-025 Each beat registers src_data to dout and drives clken=1 exactly one cycle later (latency 1); no beat -> clken=0 and dout holds its last value.
REQ-026 src_valid low in ACTIVE SHALL stall without error; counters hold and no pixel is dropped or duplicated.
REQ-027 h_cnt SHALL increment per beat; the beat with h_cnt==h_active-1 wraps h_cnt to 0 and increments v_cnt.
REQ-028 A line-end beat on a non-last line -> HBLANK for exactly H_BLANK cycles, then ACTIVE; H_BLANK=0 -> straight back to ACTIVE.
REQ-029 A line-end beat on the last line (v_cnt==v_active-1) -> VBLANK for exactly V_BLANK cycles, then IDLE with a frame_done pulse in the IDLE-entry cycle.
REQ-030 Exactly h_active*v_active clken pulses SHALL occur per completed frame.
REQ-031 The blank counter SHALL be 16 bits and SHALL count down from the parameter value to 0.
REQ-032 abort in any non-IDLE state -> IDLE next cycle, clken=0 from then on, no frame_done.
REQ-033 abort SHALL take priority over start and over a simultaneous beat; that beat is not accepted (src_ready forced 0).
REQ-034 start outside IDLE SHALL be ignored.

Reset
REQ-035 While rst_n is low, the block SHALL be in IDLE with counters at 0.
REQ-036 While rst_n is low, src_ready, clken, frame_start, frame_done and cfg_err SHALL be 0, and dout, h_active_out, v_active_out and bayer_state_start SHALL be 0.
REQ-037 Reset asserted mid-frame SHALL discard the frame; after release the block waits for a new start.

Verification
REQ-038 4x3 frame, H_BLANK=2, V_BLANK=3, src_valid always 1 -> 12 clken pulses in runs of 4 separated by 2-cycle gaps, frame_done 3 cycles after the last clken window, then src_ready=0.
REQ-039 Random src_valid gaps on a 6x4 frame -> dout sequence equals the input sequence, exactly 24 clken pulses.
REQ-040 start with h_active_cfg=0 or bayer_cfg=0011 -> cfg_err pulse, state remains IDLE, no src_ready.
REQ-041 abort asserted on the 5th beat of a 4x3 frame -> that beat is not accepted, clken is 0 from then on, no frame_done, and the next start runs a full frame.
REQ-042 rst_n asserted mid-line -> all outputs 0 immediately; after release src_ready=0 until start.
REQ-043 bayer_cfg=0100 and dims 1920x1080 -> bayer_state_start=0100 and h_active_out=1920 held constant from the first beat to frame_done.
